// File: rtl/iter_alu.sv
// rtl/iter_alu.sv - execute-stage ALU with bit-serial shifter and branch-compare flags
// Define ITER_ALU_MUL_EN to add a shift-add multiplier on ALUControl 1010.
module iter_alu #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             lt,
    output logic             ltu,
    output logic             busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ITER_ALU_MUL_EN
    localparam logic [1:0] S_MUL   = 2'd2;
`endif
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
`ifdef ITER_ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1010;
`endif

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
`ifdef ITER_ALU_MUL_EN
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [SHW:0]     mcnt_q, mcnt_d;
`endif

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_shifted;
    logic             in_is_shift;

    assign in_is_shift = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                         (alu_control == OP_SRA);

    // Single-cycle ops work straight off the input bus; unused codes fall back to add.
    always_comb begin
        alu_res = a + b;
        case (alu_control)
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            default: alu_res = a + b;
        endcase
    end

    always_comb begin
        acc_shifted = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        if (op_q == OP_SLL) begin
            acc_shifted = {acc_q[WIDTH-2:0], 1'b0};
        end else if (op_q == OP_SRL) begin
            acc_shifted = {1'b0, acc_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
`ifdef ITER_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        mcnt_d   = mcnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    b_d  = b;
                    op_d = alu_control;
                    if (in_is_shift) begin
                        acc_d   = a;
                        cnt_d   = b[SHW-1:0];
                        state_d = S_SHIFT;
`ifdef ITER_ALU_MUL_EN
                    end else if (alu_control == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = a;
                        mplier_d = b;
                        mcnt_d   = (SHW+1)'(WIDTH);
                        state_d  = S_MUL;
`endif
                    end else begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                // The count==0 cycle is spent here too, so shamt=0 still takes one cycle.
                if (cnt_q != '0) begin
                    acc_d = acc_shifted;
                    cnt_d = cnt_q - SHW'(1);
                end else begin
                    result_d = acc_q;
                    zero_d   = (acc_q == '0);
                    state_d  = S_DONE;
                end
            end
`ifdef ITER_ALU_MUL_EN
            S_MUL: begin
                if (mcnt_q != '0) begin
                    if (mplier_q[0]) begin
                        acc_d = acc_q + mcand_q;
                    end
                    mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
                    mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                    mcnt_d   = mcnt_q - (SHW+1)'(1);
                end else begin
                    result_d = acc_q;
                    zero_d   = (acc_q == '0);
                    state_d  = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
`ifdef ITER_ALU_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            mcnt_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
`ifdef ITER_ALU_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            mcnt_q   <= mcnt_d;
`endif
        end
    end

    // Compare flags come from the latched operands so they hold for the whole op.
    assign lt        = $signed(a_q) < $signed(b_q);
    assign ltu       = a_q < b_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = (state_q == S_DONE);
    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);

endmodule
